// File: rtl/stream_sma_pipe_pkg.sv
// Width and constant helpers shared by the moving-average blocks.
// The reciprocal constant is evaluated at elaboration only.
package sma_pkg;

  localparam int MAX_WINDOW = 1024;
  localparam int PTR_MAX_W  = $clog2(MAX_WINDOW);

  // Sized for the largest window; narrower windows slice the low bits.
  typedef logic [PTR_MAX_W-1:0] ptr_t;
  typedef logic [PTR_MAX_W:0]   cnt_t;

  function automatic int sma_sum_w(input int data_w, input int window);
    return data_w + $clog2(window);
  endfunction

  function automatic int sma_shift(input int in_w, input int divisor);
    return in_w + $clog2(divisor);
  endfunction

  // ceil(2^shift / divisor); shift stays below 63 for every legal width.
  function automatic logic [63:0] sma_recip(input int shift, input int divisor);
    logic [63:0] num;
    num = 64'd1 << shift;
    return (num + 64'(divisor) - 64'd1) / 64'(divisor);
  endfunction

endpackage

// File: rtl/stream_sma_pipe_if.sv
// Sample stream in, averaged stream out; no backpressure on either side.
interface stream_sma_pipe_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_full;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_full
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_full
  );
endinterface

// File: rtl/stream_sma_pipe_const_div_pipe.sv
// Two-stage floor division by a constant: multiply by a rounded-up reciprocal,
// then shift. Exact for every IN_W-bit numerator. A sideband rides along.
module const_div_pipe
  import sma_pkg::*;
#(
  parameter int IN_W    = 10,
  parameter int DIVISOR = 4,
  parameter int OUT_W   = IN_W,
  parameter int SIDE_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic [SIDE_W-1:0] out_side
);

  localparam int SHIFT   = sma_shift(IN_W, DIVISOR);
  localparam int RECIP_W = SHIFT + 1;
  localparam int PROD_W  = IN_W + RECIP_W;
  localparam logic [RECIP_W-1:0] RECIP = RECIP_W'(sma_recip(SHIFT, DIVISOR));

  logic [PROD_W-1:0] prod_reg;
  logic [PROD_W-1:0] prod_next;
  logic [SIDE_W-1:0] side_reg;
  logic              valid_reg;

  assign prod_next = PROD_W'(in_data) * PROD_W'(RECIP);

  // Data registers carry no reset; only the valid bits gate the output.
  always_ff @(posedge clk) begin
    prod_reg <= prod_next;
    side_reg <= in_side;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid_reg <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_side  <= '0;
    end else begin
      valid_reg <= in_valid;
      out_valid <= valid_reg;
      out_data  <= OUT_W'(prod_reg >> SHIFT);
      out_side  <= side_reg;
    end
  end

endmodule

// File: rtl/stream_sma_pipe.sv
// Streaming simple moving average: ring buffer plus running sum, followed by
// a constant-divisor pipeline. Three cycles from sample to result.
module stream_sma_pipe
  import sma_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WINDOW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  stream_sma_pipe_if.slave s
);

  localparam int   SUM_W    = sma_sum_w(DATA_W, WINDOW);
  localparam int   PTR_W    = $clog2(WINDOW);
  localparam ptr_t LAST     = ptr_t'(WINDOW - 1);
  localparam cnt_t FULL_CNT = cnt_t'(WINDOW);

  logic [DATA_W-1:0] mem [WINDOW];
  logic [DATA_W-1:0] old_reg;
  logic [DATA_W-1:0] evicted;
  ptr_t              wptr_reg;
  ptr_t              wptr_next;
  cnt_t              cnt_reg;
  cnt_t              cnt_next;
  logic [SUM_W-1:0]  sum_reg;
  logic [SUM_W-1:0]  sum_next;
  logic              valid_reg;
  logic              full_s1;
  logic              accept;

  assign accept  = s.in_valid && !rst && !clr;
  assign full_s1 = (cnt_reg == FULL_CNT);

  // Until the window has filled, the slot being overwritten was never written
  // since the last flush, so it counts as zero. This lets the RAM skip a reset.
  always_comb begin
    wptr_next = (wptr_reg == LAST) ? '0 : wptr_reg + ptr_t'(1);
    evicted   = full_s1 ? old_reg : '0;
    sum_next  = sum_reg + SUM_W'(s.in_data) - SUM_W'(evicted);
    cnt_next  = full_s1 ? cnt_reg : cnt_reg + cnt_t'(1);
  end

  // Registered read prefetches the slot that the next accepted sample replaces.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr_reg[PTR_W-1:0]] <= s.in_data;
      old_reg                  <= mem[wptr_next[PTR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr_reg  <= '0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= s.in_valid;
      if (s.in_valid) begin
        wptr_reg <= wptr_next;
        cnt_reg  <= cnt_next;
        sum_reg  <= sum_next;
      end
    end
  end

  const_div_pipe #(
    .IN_W    (SUM_W),
    .DIVISOR (WINDOW),
    .OUT_W   (DATA_W),
    .SIDE_W  (1)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (valid_reg),
    .in_data   (sum_reg),
    .in_side   (full_s1),
    .out_valid (s.out_valid),
    .out_data  (s.out_data),
    .out_side  (s.out_full)
  );

endmodule

// File: tb/tb_stream_sma_pipe.sv
// Directed and randomised checks of stream_sma_pipe at three parameter sets.
module tb_stream_sma_pipe;

  typedef struct {
    int unsigned data;
    bit          full;
    int unsigned cyc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr0 = 1'b0;
  logic        clr1 = 1'b0;
  logic        clr2 = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  item_t exp_q[3][$];
  item_t obs_q[3][$];

  int unsigned t2_in[5]  = '{10, 20, 30, 40, 50};
  int unsigned t2_out[5] = '{2, 7, 15, 25, 35};
  bit          t2_full[5] = '{0, 0, 0, 1, 1};
  int unsigned t3_out[5] = '{85, 170, 255, 255, 255};
  bit          t3_full[5] = '{0, 0, 1, 1, 1};
  int unsigned t4_in[4]  = '{4, 8, 12, 16};
  int unsigned t4_out[4] = '{1, 3, 6, 10};
  int unsigned t5_out[4] = '{2, 7, 15, 25};

  stream_sma_pipe_if #(.DATA_W(8))  if0 ();
  stream_sma_pipe_if #(.DATA_W(8))  if1 ();
  stream_sma_pipe_if #(.DATA_W(12)) if2 ();

  stream_sma_pipe #(.DATA_W(8),  .WINDOW(4)) dut0 (.clk(clk), .rst(rst), .clr(clr0), .s(if0));
  stream_sma_pipe #(.DATA_W(8),  .WINDOW(3)) dut1 (.clk(clk), .rst(rst), .clr(clr1), .s(if1));
  stream_sma_pipe #(.DATA_W(12), .WINDOW(7)) dut2 (.clk(clk), .rst(rst), .clr(clr2), .s(if2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.out_valid === 1'b1) obs_q[0].push_back(item_t'{32'(if0.out_data), if0.out_full, cyc});
    if (if1.out_valid === 1'b1) obs_q[1].push_back(item_t'{32'(if1.out_data), if1.out_full, cyc});
    if (if2.out_valid === 1'b1) obs_q[2].push_back(item_t'{32'(if2.out_data), if2.out_full, cyc});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] data);
    case (d)
      0: begin if0.in_valid = v; if0.in_data = data[7:0]; end
      1: begin if1.in_valid = v; if1.in_data = data[7:0]; end
      default: begin if2.in_valid = v; if2.in_data = data[11:0]; end
    endcase
  endtask

  // Result for a sample driven now appears three edges later.
  task automatic push_exp(input int d, input int unsigned data, input bit full);
    exp_q[d].push_back(item_t'{data, full, cyc + 3});
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input string tag);
    int n;
    check_val($sformatf("%s.count", tag), obs_q[d].size(), exp_q[d].size());
    n = (obs_q[d].size() < exp_q[d].size()) ? obs_q[d].size() : exp_q[d].size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s[%0d].data", tag, i), obs_q[d][i].data, exp_q[d][i].data);
      check_val($sformatf("%s[%0d].full", tag, i), 32'(obs_q[d][i].full), 32'(exp_q[d][i].full));
      check_val($sformatf("%s[%0d].cycle", tag, i), obs_q[d][i].cyc, exp_q[d][i].cyc);
    end
    $display("%s: %0d results compared", tag, n);
    obs_q[d].delete();
    exp_q[d].delete();
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, ".v0"}, 32'(if0.out_valid), 0);
    check_val({tag, ".d0"}, 32'(if0.out_data), 0);
    check_val({tag, ".f0"}, 32'(if0.out_full), 0);
    check_val({tag, ".v1"}, 32'(if1.out_valid), 0);
    check_val({tag, ".d1"}, 32'(if1.out_data), 0);
    check_val({tag, ".f1"}, 32'(if1.out_full), 0);
    check_val({tag, ".v2"}, 32'(if2.out_valid), 0);
    check_val({tag, ".d2"}, 32'(if2.out_data), 0);
    check_val({tag, ".f2"}, 32'(if2.out_full), 0);
  endtask

  initial begin
    int unsigned hist[$];
    int unsigned acc;
    int unsigned data;
    int unsigned sum;
    bit          v;
    bit          did_rst;

    for (int d = 0; d < 3; d++) drive(d, 1'b0, 0);

    // Reset, then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    tick();
    rst = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check_idle("idle");
    check_dut(0, "idle_out0");

    // W=4 back-to-back ramp
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, t2_in[k]);
      push_exp(0, t2_out[k], t2_full[k]);
      tick();
    end
    drive(0, 1'b0, 0);
    repeat (6) tick();
    check_dut(0, "ramp_w4");

    // W=3 saturated samples
    for (int k = 0; k < 5; k++) begin
      drive(1, 1'b1, 255);
      push_exp(1, t3_out[k], t3_full[k]);
      tick();
    end
    drive(1, 1'b0, 0);
    repeat (6) tick();
    check_dut(1, "max_w3");

    // Gapped input on a flushed W=4 engine
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, t4_in[k]);
      push_exp(0, t4_out[k], k == 3);
      tick();
      drive(0, 1'b0, 0);
      repeat (2) tick();
    end
    repeat (6) tick();
    check_dut(0, "gapped");

    // Flush with a colliding sample; samples 5 and 6 are still in flight
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'b1, 10 * (k + 1));
      if (k < 4) push_exp(0, t5_out[k], k == 3);
      tick();
    end
    clr0 = 1'b1;
    drive(0, 1'b1, 99);
    tick();
    clr0 = 1'b0;
    drive(0, 1'b1, 40);
    push_exp(0, 10, 1'b0);
    tick();
    drive(0, 1'b0, 0);
    repeat (6) tick();
    check_dut(0, "flush");

    // Random stream, W=7, 12-bit, with one reset mid-stream
    acc = 0;
    did_rst = 1'b0;
    while (acc < 10000) begin
      v = 1'($urandom_range(0, 1));
      data = $urandom_range(0, 4095);
      if (!did_rst && acc == 5000) begin
        did_rst = 1'b1;
        rst = 1'b1;
        drive(2, v, data);
        while (exp_q[2].size() > 0 && exp_q[2][$].cyc >= cyc + 1) void'(exp_q[2].pop_back());
        hist.delete();
        tick();
        rst = 1'b0;
        continue;
      end
      if (v) begin
        drive(2, 1'b1, data);
        hist.push_back(data);
        if (hist.size() > 7) void'(hist.pop_front());
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        push_exp(2, sum / 7, hist.size() == 7);
        acc++;
      end else begin
        drive(2, 1'b0, 'x);
      end
      tick();
    end
    drive(2, 1'b0, 0);
    repeat (6) tick();
    check_dut(2, "random_w7");
    check_dut(0, "quiet_out0");
    check_dut(1, "quiet_out1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
